// File: rtl/jtframe_sndcmd_fifo_pkg.sv
// Shared defaults and IRQ mode constants for the sound command channel.
package jtframe_sndcmd_fifo_pkg;
  localparam int SND_DW         = 8;
  localparam int SND_AW         = 2;
  localparam int IRQ_EDGE_MODE  = 0;
  localparam int IRQ_LEVEL_MODE = 1;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/jtframe_sndcmd_ram.sv
// Command storage: synchronous write, asynchronous read, no reset on contents.
module jtframe_sndcmd_ram #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/jtframe_sndcmd_fifo.sv
// Main-CPU -> sound-CPU command FIFO with sound IRQ, reply latch, overflow flag
// and occupancy count. All outputs are registered.
module jtframe_sndcmd_fifo
  import jtframe_sndcmd_fifo_pkg::*;
#(
  parameter int DW        = SND_DW,
  parameter int AW        = SND_AW,
  parameter int IRQ_LEVEL = IRQ_LEVEL_MODE
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_main_we,
  input  logic [DW-1:0] i_main_din,
  input  logic          i_main_rd,
  output logic [DW-1:0] o_main_reply,
  output logic          o_reply_new,
  output logic          o_ovf,
  input  logic          i_ovf_clr,
  output logic [AW:0]   o_count,
  input  logic          i_snd_rd,
  output logic [DW-1:0] o_snd_dout,
  input  logic          i_snd_we,
  input  logic [DW-1:0] i_snd_din,
  input  logic          i_irq_ack,
  output logic          o_int_n
);
  localparam logic [AW:0] DEPTH = (AW+1)'(fifo_depth(AW));

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full, w_empty, w_push, w_pop, w_ovf_set;
  logic [AW:0]   w_count_nxt, w_old_left;
  logic [DW-1:0] w_next_head;

  assign w_full    = (r_count == DEPTH);
  assign w_empty   = (r_count == '0);
  // A full FIFO still accepts a push when a pop frees a slot in the same clock.
  assign w_push    = i_main_we & (~w_full | i_snd_rd);
  assign w_pop     = i_snd_rd & ~w_empty;
  assign w_ovf_set = i_main_we & w_full & ~i_snd_rd;

  assign w_old_left  = r_count - {{AW{1'b0}}, w_pop};
  assign w_count_nxt = w_old_left + {{AW{1'b0}}, w_push};

  jtframe_sndcmd_ram #(.DW(DW), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_main_din),
    .i_raddr (r_rd_ptr + AW'(1)),
    .o_rdata (w_next_head)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      o_snd_dout <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      // Head comes from the incoming word when nothing older remains stored.
      if (w_push && w_old_left == '0)
        o_snd_dout <= i_main_din;
      else if (w_pop && w_old_left != '0)
        o_snd_dout <= w_next_head;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_int_n <= 1'b1;
    end else if (IRQ_LEVEL != IRQ_EDGE_MODE) begin
      o_int_n <= (w_count_nxt == '0);
    end else if (w_push) begin
      o_int_n <= 1'b0;
    end else if (i_irq_ack) begin
      o_int_n <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_main_reply <= '0;
      o_reply_new  <= 1'b0;
      o_ovf        <= 1'b0;
    end else begin
      if (i_snd_we) begin
        o_main_reply <= i_snd_din;
        o_reply_new  <= 1'b1;
      end else if (i_main_rd) begin
        o_reply_new  <= 1'b0;
      end
      if (w_ovf_set)      o_ovf <= 1'b1;
      else if (i_ovf_clr) o_ovf <= 1'b0;
    end
  end

  assign o_count = r_count;
endmodule

// File: tb/tb_jtframe_sndcmd_fifo.sv
// Scoreboard bench: two instances (level and edge IRQ) share one stimulus stream.
module tb_jtframe_sndcmd_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       main_we, main_rd, ovf_clr, snd_rd, snd_we, irq_ack;
  logic [7:0] main_din, snd_din;

  logic [7:0] l_reply, l_dout, e_reply, e_dout;
  logic       l_new, l_ovf, l_int_n, e_new, e_ovf, e_int_n;
  logic [2:0] l_count, e_count;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  jtframe_sndcmd_fifo #(.DW(8), .AW(2), .IRQ_LEVEL(1)) u_lvl (
    .i_clk(clk), .i_rst_n(rst_n), .i_main_we(main_we), .i_main_din(main_din),
    .i_main_rd(main_rd), .o_main_reply(l_reply), .o_reply_new(l_new), .o_ovf(l_ovf),
    .i_ovf_clr(ovf_clr), .o_count(l_count), .i_snd_rd(snd_rd), .o_snd_dout(l_dout),
    .i_snd_we(snd_we), .i_snd_din(snd_din), .i_irq_ack(irq_ack), .o_int_n(l_int_n)
  );

  jtframe_sndcmd_fifo #(.DW(8), .AW(2), .IRQ_LEVEL(0)) u_edge (
    .i_clk(clk), .i_rst_n(rst_n), .i_main_we(main_we), .i_main_din(main_din),
    .i_main_rd(main_rd), .o_main_reply(e_reply), .o_reply_new(e_new), .o_ovf(e_ovf),
    .i_ovf_clr(ovf_clr), .o_count(e_count), .i_snd_rd(snd_rd), .o_snd_dout(e_dout),
    .i_snd_we(snd_we), .i_snd_din(snd_din), .i_irq_ack(irq_ack), .o_int_n(e_int_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; strobes last exactly one clock.
  task automatic tick();
    @(posedge clk);
    #1;
    main_we = 0; main_rd = 0; ovf_clr = 0; snd_rd = 0; snd_we = 0; irq_ack = 0;
  endtask

  task automatic op(input logic we, input logic [7:0] d, input logic rd, input logic ack);
    bit pop_ok, push_ok;
    pop_ok  = rd && (m_cnt > 0);
    push_ok = we && ((m_cnt < 4) || rd);
    if (push_ok) exp_q.push_back(d);
    m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
    main_we = we; main_din = d; snd_rd = rd; irq_ack = ack;
    tick();
  endtask

  // Monitor: every pop presented to a non-empty FIFO must show the oldest queued command.
  always @(negedge clk) begin
    if (rst_n && snd_rd && l_count != 3'd0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected: got %0h expected none", l_dout);
      end else begin
        chk("pop_data", {24'd0, l_dout}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 0; main_we = 0; main_rd = 0; ovf_clr = 0; snd_rd = 0; snd_we = 0; irq_ack = 0;
    main_din = 8'h00; snd_din = 8'h00;
    #22 rst_n = 1;
    chk("rst_count", {29'd0, l_count}, 0);
    chk("rst_int_n", {31'd0, l_int_n}, 1);
    chk("rst_edge_int_n", {31'd0, e_int_n}, 1);
    chk("rst_dout", {24'd0, l_dout}, 0);
    tick();

    // reset in the middle of traffic
    op(1, 8'h71, 0, 0); op(1, 8'h72, 0, 0); op(1, 8'h73, 0, 0);
    chk("pre_rst_count", {29'd0, l_count}, 3);
    rst_n = 0;
    #1;
    chk("mid_rst_count", {29'd0, l_count}, 0);
    chk("mid_rst_int_n", {31'd0, l_int_n}, 1);
    chk("mid_rst_dout", {24'd0, l_dout}, 0);
    chk("mid_rst_reply_new", {31'd0, l_new}, 0);
    exp_q.delete(); m_cnt = 0;
    #1 rst_n = 1;
    tick();

    // fill, overflow, drain
    op(1, 8'h11, 0, 0); chk("fill1_count", {29'd0, l_count}, 1);
    chk("fill1_dout", {24'd0, l_dout}, 8'h11);
    op(1, 8'h22, 0, 0); op(1, 8'h33, 0, 0); op(1, 8'h44, 0, 0);
    chk("full_count", {29'd0, l_count}, 4);
    op(1, 8'h55, 0, 0);
    chk("ovf_set", {31'd0, l_ovf}, 1);
    chk("ovf_count", {29'd0, l_count}, 4);
    ovf_clr = 1; tick();
    chk("ovf_clr", {31'd0, l_ovf}, 0);
    ovf_clr = 1; op(1, 8'h55, 0, 0);
    chk("ovf_set_wins", {31'd0, l_ovf}, 1);
    ovf_clr = 1; tick();
    for (int i = 0; i < 4; i++) op(0, 8'h00, 1, 0);
    chk("drain_count", {29'd0, l_count}, 0);
    chk("drain_int_n", {31'd0, l_int_n}, 1);
    op(0, 8'h00, 1, 0);
    chk("empty_pop_dout", {24'd0, l_dout}, 8'h44);
    chk("empty_pop_count", {29'd0, l_count}, 0);

    // push and pop together while full
    op(1, 8'hA1, 0, 0); op(1, 8'hA2, 0, 0); op(1, 8'hA3, 0, 0); op(1, 8'hA4, 0, 0);
    op(1, 8'h66, 1, 0);
    chk("fullrw_count", {29'd0, l_count}, 4);
    chk("fullrw_ovf", {31'd0, l_ovf}, 0);
    for (int i = 0; i < 4; i++) op(0, 8'h00, 1, 0);
    chk("fullrw_last", {24'd0, l_dout}, 8'h66);

    // push into empty with a simultaneous pop: pop ignored
    op(1, 8'h77, 1, 0);
    chk("empty_rw_count", {29'd0, l_count}, 1);
    chk("empty_rw_dout", {24'd0, l_dout}, 8'h77);
    op(0, 8'h00, 1, 0);
    irq_ack = 1; tick();
    chk("edge_idle_int_n", {31'd0, e_int_n}, 1);

    // level IRQ
    op(1, 8'hA5, 0, 0);
    chk("lvl_push_int_n", {31'd0, l_int_n}, 0);
    op(0, 8'h00, 0, 1);
    chk("lvl_ack_int_n", {31'd0, l_int_n}, 0);
    op(0, 8'h00, 1, 0);
    chk("lvl_pop_int_n", {31'd0, l_int_n}, 1);

    // edge IRQ
    op(1, 8'h01, 0, 0);
    chk("edge_push_int_n", {31'd0, e_int_n}, 0);
    op(0, 8'h00, 0, 1);
    chk("edge_ack_int_n", {31'd0, e_int_n}, 1);
    chk("edge_ack_count", {29'd0, e_count}, 1);
    op(1, 8'h02, 0, 1);
    chk("edge_push_wins", {31'd0, e_int_n}, 0);
    op(0, 8'h00, 1, 0); op(0, 8'h00, 1, 0);
    chk("edge_drained_int_n", {31'd0, e_int_n}, 0);
    chk("lvl_drained_int_n", {31'd0, l_int_n}, 1);

    // reply latch
    snd_we = 1; snd_din = 8'h5A; tick();
    chk("reply_data", {24'd0, l_reply}, 8'h5A);
    chk("reply_new", {31'd0, l_new}, 1);
    snd_we = 1; snd_din = 8'hC3; main_rd = 1; tick();
    chk("reply_data2", {24'd0, l_reply}, 8'hC3);
    chk("reply_new_wins", {31'd0, l_new}, 1);
    main_rd = 1; tick();
    chk("reply_cleared", {31'd0, l_new}, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
